// File: rtl/speed_meter.sv
// Bike-computer speed block: measures reed-pulse intervals in en-ticks and obtains the speed
// from a shared divider through a req/start/busy/ready handshake, with watchdog and saturation.
module speed_meter #(
    parameter int               WIDTH     = 16,
    parameter int               SPEED_W   = 12,
    parameter logic [15:0]      CONST     = 16'h49BA,
    parameter int               SPEED_MAX = 99,
    parameter int               MIN_TICKS = 4,
    parameter logic [WIDTH-1:0] TIMEOUT   = 16'hFFFF,
    parameter int               DIV_WDOG  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               reed,
    input  logic [7:0]         circ,
    input  logic               start,
    input  logic               clear_max,
    input  logic               busy,
    input  logic               ready,
    input  logic [WIDTH-1:0]   dividerres,
    output logic               div_req,
    output logic               div_start,
    output logic [WIDTH-1:0]   dividend,
    output logic [WIDTH-1:0]   divisor,
    output logic [SPEED_W-1:0] speed,
    output logic [SPEED_W-1:0] max_speed,
    output logic               valid,
    output logic               stopped,
    output logic               err
);
    localparam int CW   = WIDTH + 8;
    localparam int WD_W = $clog2(DIV_WDOG + 1);

    typedef enum logic [1:0] {IDLE, WAIT_FREE, LAUNCH, WAIT_RES} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   cnt_reg, tim_reg;
    logic               reed_q, stopped_reg;
    logic [CW-1:0]      cico_reg;
    logic [WD_W-1:0]    wdog_reg;
    logic [SPEED_W-1:0] speed_reg, speed_next, max_reg, max_next, sat_speed;
    logic               valid_reg, valid_next, err_reg, err_next;
    logic               div_req_reg, div_req_next, div_start_reg, div_start_next;
    logic [WIDTH-1:0]   dividend_reg, dividend_next, divisor_reg, divisor_next;
    logic               reed_rise, wdog_hit, upper_nz;

    assign reed_rise = reed & ~reed_q;

    // Interval counter; a reed edge arriving after standstill restarts timing with tim=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            tim_reg     <= '0;
            reed_q      <= 1'b0;
            stopped_reg <= 1'b0;
        end else begin
            reed_q <= reed;
            if (reed_rise && cnt_reg >= WIDTH'(MIN_TICKS)) begin
                tim_reg     <= (cnt_reg == TIMEOUT) ? '0 : cnt_reg;
                cnt_reg     <= '0;
                stopped_reg <= 1'b0;
            end else begin
                if (en && cnt_reg != TIMEOUT)
                    cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == TIMEOUT) begin
                    stopped_reg <= 1'b1;
                    tim_reg     <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            wdog_reg <= '0;
        else if (state_reg == LAUNCH || state_reg == WAIT_RES)
            wdog_reg <= wdog_reg + 1'b1;
        else
            wdog_reg <= '0;
    end

    assign wdog_hit = (wdog_reg == WD_W'(DIV_WDOG - 1));
    assign upper_nz = |dividerres[WIDTH-1:SPEED_W];
    assign sat_speed = (upper_nz || dividerres[SPEED_W-1:0] > SPEED_W'(SPEED_MAX))
                       ? SPEED_W'(SPEED_MAX) : dividerres[SPEED_W-1:0];

    always_comb begin
        state_next     = state_reg;
        speed_next     = speed_reg;
        max_next       = clear_max ? '0 : max_reg;
        valid_next     = valid_reg;
        err_next       = err_reg;
        div_req_next   = div_req_reg;
        div_start_next = div_start_reg;
        dividend_next  = dividend_reg;
        divisor_next   = divisor_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    err_next = 1'b0;
                    if (tim_reg == '0) begin
                        speed_next = '0;
                        valid_next = 1'b1;
                    end else begin
                        valid_next   = 1'b0;
                        div_req_next = 1'b1;
                        state_next   = WAIT_FREE;
                    end
                end
            end
            WAIT_FREE: begin
                if (!busy) begin
                    dividend_next  = cico_reg[WIDTH+7:8];
                    divisor_next   = tim_reg;
                    div_start_next = 1'b1;
                    state_next     = LAUNCH;
                end
            end
            LAUNCH: begin
                if (wdog_hit) begin
                    div_start_next = 1'b0;
                    div_req_next   = 1'b0;
                    err_next       = 1'b1;
                    valid_next     = 1'b1;
                    state_next     = IDLE;
                end else if (busy) begin
                    div_start_next = 1'b0;
                    state_next     = WAIT_RES;
                end
            end
            WAIT_RES: begin
                // A result arriving on the watchdog's last cycle still wins.
                if (ready) begin
                    speed_next   = sat_speed;
                    valid_next   = 1'b1;
                    div_req_next = 1'b0;
                    if (sat_speed > max_next)
                        max_next = sat_speed;
                    state_next   = IDLE;
                end else if (wdog_hit) begin
                    div_start_next = 1'b0;
                    div_req_next   = 1'b0;
                    err_next       = 1'b1;
                    valid_next     = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cico_reg      <= CW'(circ) * CW'(CONST);
            speed_reg     <= '0;
            max_reg       <= '0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
            div_req_reg   <= 1'b0;
            div_start_reg <= 1'b0;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            speed_reg     <= speed_next;
            max_reg       <= max_next;
            valid_reg     <= valid_next;
            err_reg       <= err_next;
            div_req_reg   <= div_req_next;
            div_start_reg <= div_start_next;
            dividend_reg  <= dividend_next;
            divisor_reg   <= divisor_next;
        end
    end

    assign div_req   = div_req_reg;
    assign div_start = div_start_reg;
    assign dividend  = dividend_reg;
    assign divisor   = divisor_reg;
    assign speed     = speed_reg;
    assign max_speed = max_reg;
    assign valid     = valid_reg;
    assign stopped   = stopped_reg;
    assign err       = err_reg;
endmodule

// File: tb/tb_speed_meter.sv
// Directed bench for speed_meter with an inline divider model driven from the stimulus sequence.
module tb_speed_meter;
    logic        clk = 1'b0;
    logic        rst, en, reed, start, clear_max, busy, ready;
    logic [7:0]  circ;
    logic [15:0] dividerres, dividend, divisor;
    logic        div_req, div_start, valid, stopped, err;
    logic [11:0] speed, max_speed;

    int checks = 0;
    int failures = 0;

    speed_meter #(.TIMEOUT(16'd600)) dut (
        .clk(clk), .rst(rst), .en(en), .reed(reed), .circ(circ), .start(start),
        .clear_max(clear_max), .busy(busy), .ready(ready), .dividerres(dividerres),
        .div_req(div_req), .div_start(div_start), .dividend(dividend), .divisor(divisor),
        .speed(speed), .max_speed(max_speed), .valid(valid), .stopped(stopped), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Two accepted reed edges t en-ticks apart: tim becomes t.
    task automatic interval(input int t);
        reed = 1'b1; tick(1); reed = 1'b0;
        tick(t);
        reed = 1'b1; tick(1); reed = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    // Divider model: waits for div_start, checks operands, returns the quotient after a few cycles.
    task automatic divide(input int exp_divisor, input logic clr);
        int n = 0;
        while (div_start !== 1'b1 && n < 50) begin tick(1); n++; end
        chk("div_start_seen", div_start, 1);
        chk("dividend", dividend, 14745);
        chk("divisor", divisor, exp_divisor);
        busy = 1'b1; tick(1);
        tick(3);
        ready = 1'b1; busy = 1'b0; clear_max = clr;
        dividerres = (divisor == 16'd0) ? 16'hFFFF : dividend / divisor;
        tick(1);
        ready = 1'b0; clear_max = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        rst = 1'b1; en = 1'b1; reed = 1'b0; start = 1'b0; clear_max = 1'b0;
        busy = 1'b0; ready = 1'b0; circ = 8'd200; dividerres = '0;
        tick(3);
        chk("rst_speed", speed, 0);
        chk("rst_valid", valid, 0);
        chk("rst_div_req", div_req, 0);
        chk("rst_dividend", dividend, 0);
        rst = 1'b0;
        tick(10);

        // 1: tim=150 -> 14745/150 = 98
        interval(150);
        start_pulse();
        chk("t1_div_req", div_req, 1);
        chk("t1_valid_low", valid, 0);
        divide(150, 1'b0);
        chk("t1_speed", speed, 98);
        chk("t1_valid", valid, 1);
        chk("t1_max", max_speed, 98);
        chk("t1_req_released", div_req, 0);

        // 2: tim=100 -> 147 saturates to 99; tim=300 -> 49, max stays 99
        interval(100);
        start_pulse();
        divide(100, 1'b0);
        chk("t2_speed_sat", speed, 99);
        chk("t2_max", max_speed, 99);

        // 3: bounce at cnt=2 is ignored, so the division still uses tim=300
        interval(300);
        tick(2);
        reed = 1'b1; tick(1); reed = 1'b0;
        start_pulse();
        divide(300, 1'b0);
        chk("t3_speed", speed, 49);
        chk("t3_max_hold", max_speed, 99);
        n = 0;
        while (stopped !== 1'b1 && n < 800) begin tick(1); n++; end
        chk("t3_stopped", stopped, 1);
        start_pulse();
        chk("t3_bypass_valid", valid, 1);
        chk("t3_bypass_speed", speed, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (div_req !== 1'b0) bad++;
            tick(1);
        end
        chk("t3_no_div_req", bad, 0);

        // wheel turns again: stopped clears, tim=150
        interval(150);
        chk("t3_restart", stopped, 0);

        // 4: divider busy for 20 cycles -> no div_start until it frees up
        busy = 1'b1;
        start_pulse();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (div_start !== 1'b0) bad++;
            tick(1);
        end
        chk("t4_start_held", bad, 0);
        chk("t4_req_held", div_req, 1);
        busy = 1'b0;
        divide(150, 1'b0);
        chk("t4_speed", speed, 98);

        // 5: ready never arrives -> watchdog abort after 255 cycles
        start_pulse();
        n = 0;
        while (div_start !== 1'b1 && n < 50) begin tick(1); n++; end
        chk("t5_launch", div_start, 1);
        busy = 1'b1;
        n = 0;
        while (err !== 1'b1 && n < 400) begin tick(1); n++; end
        chk("t5_wdog_cycles", n, 255);
        chk("t5_err", err, 1);
        chk("t5_valid", valid, 1);
        chk("t5_div_req", div_req, 0);
        chk("t5_div_start", div_start, 0);
        chk("t5_speed_kept", speed, 98);
        busy = 1'b0;
        tick(2);

        // 6: reset in WAIT_RES clears everything next cycle
        start_pulse();
        n = 0;
        while (div_start !== 1'b1 && n < 50) begin tick(1); n++; end
        busy = 1'b1; tick(2);
        rst = 1'b1; tick(1);
        chk("t6_rst_req", div_req, 0);
        chk("t6_rst_start", div_start, 0);
        chk("t6_rst_speed", speed, 0);
        chk("t6_rst_max", max_speed, 0);
        chk("t6_rst_err", err, 0);
        rst = 1'b0; busy = 1'b0;
        tick(10);
        interval(150);
        start_pulse();
        divide(150, 1'b0);
        chk("t6_speed", speed, 98);
        chk("t6_max", max_speed, 98);
        // clear_max coincident with capture: cleared then loaded with 49
        interval(300);
        start_pulse();
        divide(300, 1'b1);
        chk("t6_clr_speed", speed, 49);
        chk("t6_clr_max", max_speed, 49);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
